// File: rtl/booth_pkg.sv
// Shared widths, FSM encodings and saturation limits for the Booth product accumulator.
package booth_pkg;

    localparam int unsigned DEF_PROD_W = 16;
    localparam int unsigned DEF_ACC_W  = 24;
    localparam int unsigned DEF_LEN_W  = 8;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ACCUM = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam logic signed [DEF_ACC_W-1:0] ACC_MAX = {1'b0, {(DEF_ACC_W-1){1'b1}}};
    localparam logic signed [DEF_ACC_W-1:0] ACC_MIN = {1'b1, {(DEF_ACC_W-1){1'b0}}};

endpackage

// File: rtl/sat_add.sv
// Combinational signed accumulate step: acc + sign-extended product, clamped to ACC_W.
module sat_add
    import booth_pkg::*;
#(
    parameter int unsigned PROD_W = DEF_PROD_W,
    parameter int unsigned ACC_W  = DEF_ACC_W
) (
    input  logic [ACC_W-1:0]  acc,
    input  logic [PROD_W-1:0] product,
    output logic [ACC_W-1:0]  sum,
    output logic              ovf
);

    logic [ACC_W:0] sum_wide;
    logic [ACC_W:0] prod_ext;

    assign prod_ext = {{(ACC_W+1-PROD_W){product[PROD_W-1]}}, product};
    assign sum_wide = {acc[ACC_W-1], acc} + prod_ext;

    // Guard bit disagreeing with the ACC_W sign bit means the true sum left range.
    assign ovf = sum_wide[ACC_W] ^ sum_wide[ACC_W-1];

    always_comb begin
        sum = sum_wide[ACC_W-1:0];
        if (ovf) begin
            sum = sum_wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        end
    end

endmodule

// File: rtl/booth_product_accumulator.sv
// Sums a burst of Booth products into a saturating signed accumulator with
// valid/ready handshakes on both the product input and the result output.
module booth_product_accumulator
    import booth_pkg::*;
#(
    parameter int unsigned PROD_W = DEF_PROD_W,
    parameter int unsigned ACC_W  = DEF_ACC_W,
    parameter int unsigned LEN_W  = DEF_LEN_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] product,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  acc_out,
    output logic              sat_flag,
    output logic              busy
);

    logic [1:0]       state_q;
    logic [ACC_W-1:0] acc_q;
    logic             sat_q;
    logic [LEN_W-1:0] rem_q;

    logic [ACC_W-1:0] sum;
    logic             ovf;
    logic             xfer;

    sat_add #(
        .PROD_W (PROD_W),
        .ACC_W  (ACC_W)
    ) u_sat_add (
        .acc     (acc_q),
        .product (product),
        .sum     (sum),
        .ovf     (ovf)
    );

    assign in_ready  = (state_q == ST_ACCUM);
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q != ST_IDLE);
    assign xfer      = in_valid & in_ready;
    assign acc_out   = acc_q;
    assign sat_flag  = sat_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            sat_q   <= 1'b0;
            rem_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        acc_q   <= '0;
                        sat_q   <= 1'b0;
                        rem_q   <= len;
                        state_q <= (len != '0) ? ST_ACCUM : ST_DONE;
                    end
                end
                ST_ACCUM: begin
                    if (xfer) begin
                        acc_q <= sum;
                        sat_q <= sat_q | ovf;
                        rem_q <= rem_q - LEN_W'(1);
                        if (rem_q == LEN_W'(1)) begin
                            state_q <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    // start is deliberately ignored here, even alongside the handshake.
                    if (out_ready) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_booth_product_accumulator.sv
// Directed self-checking bench for booth_product_accumulator, built with ACC_W=18
// so saturation is reachable with 8x8 Booth products.
module tb_booth_product_accumulator;

    localparam int unsigned PROD_W = 16;
    localparam int unsigned ACC_W  = 18;
    localparam int unsigned LEN_W  = 8;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic                     start;
    logic [LEN_W-1:0]         len;
    logic                     in_valid;
    logic                     in_ready;
    logic signed [PROD_W-1:0] product;
    logic                     out_valid;
    logic                     out_ready;
    logic signed [ACC_W-1:0]  acc_out;
    logic                     sat_flag;
    logic                     busy;

    int n_checks = 0;
    int n_fail   = 0;

    booth_product_accumulator #(
        .PROD_W (PROD_W),
        .ACC_W  (ACC_W),
        .LEN_W  (LEN_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .len       (len),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .product   (product),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .acc_out   (acc_out),
        .sat_flag  (sat_flag),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic begin_burst(input int n);
        start = 1'b1;
        len   = LEN_W'(n);
        step();
        start = 1'b0;
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        len       = '0;
        in_valid  = 1'b0;
        product   = '0;
        out_ready = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        check_eq("reset_acc", int'(acc_out), 0);
        check_eq("reset_sat", int'(sat_flag), 0);
        check_eq("reset_in_ready", int'(in_ready), 0);
        check_eq("reset_out_valid", int'(out_valid), 0);
        check_eq("reset_busy", int'(busy), 0);

        // Basic burst: 256 - 10 + 300 = 546
        begin_burst(3);
        check_eq("basic_in_ready", int'(in_ready), 1);
        check_eq("basic_busy", int'(busy), 1);
        in_valid = 1'b1;
        product  = 256;
        step();
        check_eq("basic_not_done_early", int'(out_valid), 0);
        product = -10;
        step();
        product = 300;
        step();
        in_valid = 1'b0;
        check_eq("basic_out_valid", int'(out_valid), 1);
        check_eq("basic_in_ready_done", int'(in_ready), 0);
        check_eq("basic_acc", int'(acc_out), 546);
        check_eq("basic_sat", int'(sat_flag), 0);
        handshake();
        check_eq("basic_idle_busy", int'(busy), 0);
        check_eq("basic_idle_out_valid", int'(out_valid), 0);
        check_eq("basic_acc_held", int'(acc_out), 546);

        // Stalls and backpressure: 1000 - 3000 = -2000
        begin_burst(2);
        in_valid = 1'b1;
        product  = 1000;
        step();
        in_valid = 1'b0;
        product  = -3000;
        step();
        step();
        check_eq("stall_acc", int'(acc_out), 1000);
        check_eq("stall_out_valid", int'(out_valid), 0);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check_eq("bp_out_valid", int'(out_valid), 1);
            check_eq("bp_acc", int'(acc_out), -2000);
            step();
        end
        handshake();
        check_eq("bp_idle_busy", int'(busy), 0);
        check_eq("bp_idle_out_valid", int'(out_valid), 0);

        // Zero length: straight to DONE, offered product not consumed
        in_valid = 1'b1;
        product  = 55;
        begin_burst(0);
        check_eq("zero_out_valid", int'(out_valid), 1);
        check_eq("zero_in_ready", int'(in_ready), 0);
        check_eq("zero_acc", int'(acc_out), 0);
        check_eq("zero_sat", int'(sat_flag), 0);
        step();
        check_eq("zero_acc_hold", int'(acc_out), 0);
        in_valid = 1'b0;
        handshake();
        check_eq("zero_idle", int'(busy), 0);

        // Positive saturation: 9 x 16384 exceeds 131071
        begin_burst(9);
        in_valid = 1'b1;
        product  = 16384;
        for (int i = 0; i < 7; i++) step();
        check_eq("satp_pre_acc", int'(acc_out), 114688);
        check_eq("satp_pre_flag", int'(sat_flag), 0);
        step();
        step();
        in_valid = 1'b0;
        check_eq("satp_out_valid", int'(out_valid), 1);
        check_eq("satp_acc", int'(acc_out), 131071);
        check_eq("satp_flag", int'(sat_flag), 1);
        handshake();
        check_eq("satp_flag_sticky_idle", int'(sat_flag), 1);

        // Negative saturation: 9 x -16256 below -131072; flag cleared on start
        begin_burst(9);
        check_eq("satn_flag_cleared", int'(sat_flag), 0);
        check_eq("satn_acc_cleared", int'(acc_out), 0);
        in_valid = 1'b1;
        product  = -16256;
        for (int i = 0; i < 9; i++) step();
        in_valid = 1'b0;
        check_eq("satn_out_valid", int'(out_valid), 1);
        check_eq("satn_acc", int'(acc_out), -131072);
        check_eq("satn_flag", int'(sat_flag), 1);
        handshake();

        // Reset mid-burst abandons the burst
        begin_burst(4);
        in_valid = 1'b1;
        product  = 5;
        step();
        step();
        in_valid = 1'b0;
        check_eq("rst_mid_acc_pre", int'(acc_out), 10);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check_eq("rst_mid_busy", int'(busy), 0);
        check_eq("rst_mid_out_valid", int'(out_valid), 0);
        check_eq("rst_mid_acc", int'(acc_out), 0);
        check_eq("rst_mid_in_ready", int'(in_ready), 0);
        begin_burst(1);
        in_valid = 1'b1;
        product  = 7;
        step();
        in_valid = 1'b0;
        check_eq("fresh_out_valid", int'(out_valid), 1);
        check_eq("fresh_acc", int'(acc_out), 7);
        handshake();

        // start ignored during ACCUM and alongside the DONE handshake
        begin_burst(2);
        in_valid = 1'b1;
        product  = 10;
        start    = 1'b1;
        len      = 5;
        step();
        start   = 1'b0;
        product = 20;
        step();
        in_valid = 1'b0;
        check_eq("ign_out_valid", int'(out_valid), 1);
        check_eq("ign_acc", int'(acc_out), 30);
        start = 1'b1;
        len   = 3;
        handshake();
        start = 1'b0;
        check_eq("ign_idle_busy", int'(busy), 0);
        step();
        check_eq("ign_still_idle", int'(busy), 0);
        check_eq("ign_in_ready", int'(in_ready), 0);
        check_eq("ign_acc_held", int'(acc_out), 30);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
